sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 89 ++++++++
 tb/tb_sub_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial 8-bit subtractor with scrambled operands and key-gated sequencing.
// The result is produced LSB first over eight cycles and held until acknowledged.
module sub_serial #(
    parameter logic [7:0] A_MASK = 8'h32,
    parameter logic [7:0] B_MASK = 8'hD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SUB    = 3'd1,
        DONE   = 3'd2,
        delay0 = 3'd3,
        delay1 = 3'd4,
        delay2 = 3'd5,
        delay3 = 3'd6,
        delay4 = 3'd7
    } state_t;

    state_t     state;
    state_t     next;
    logic [2:0] count;
    logic       borrow;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       diff;
    logic       borrow_next;

    assign diff        = a_reg[0] ^ b_reg[0] ^ borrow;
    assign borrow_next = (~a_reg[0] & b_reg[0])
                       | (~a_reg[0] & borrow)
                       | (b_reg[0] & borrow);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Key bits are checked on the live inputs, not the loaded operands.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:   next = en ? delay0 : IDLE;
            delay0: next = a[2] ? IDLE : SUB;
            SUB:    next = (count == 3'd7) ? delay1 : SUB;
            delay1: next = a[1] ? IDLE : DONE;
            DONE:   next = en ? IDLE : DONE;
            delay2: next = b[3] ? delay0 : IDLE;
            delay3: next = a[4] ? IDLE : delay1;
            delay4: next = b[5] ? IDLE : delay2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= 8'h00;
            b_reg  <= 8'h00;
            out    <= 8'h00;
            count  <= 3'd0;
            borrow <= 1'b0;
        end else begin
            if (state == IDLE && en) begin
                a_reg  <= a ^ A_MASK;
                b_reg  <= b ^ B_MASK;
                out    <= 8'h00;
                count  <= 3'd0;
                borrow <= 1'b0;
            end else if (state == SUB) begin
                out    <= {diff, out[7:1]};
                borrow <= borrow_next;
                a_reg  <= {1'b0, a_reg[7:1]};
                b_reg  <= {1'b0, b_reg[7:1]};
                count  <= count + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed cases plus randomized
// operations against an arithmetic reference of the subtract and its timing.
module tb_sub_serial;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       done;

    int compared;
    int mismatched;

    sub_serial dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .a    (a),
        .b    (b),
        .out  (out),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One full operation; noisy toggles en while it must be ignored.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input bit noisy);
        logic [7:0] res;
        bit         key0;
        bit         key1;
        bit         early;
        res   = 8'((ta ^ 8'h32) - (tb_v ^ 8'hD5));
        key0  = !ta[2];
        key1  = !ta[1];
        early = 0;
        @(negedge clk);
        a  = ta;
        b  = tb_v;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            en = (noisy && key0) ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            if (i < 10 && done) early = 1;
        end
        en = 1'b0;
        chk("done_early", {7'b0, early}, 8'h00);
        chk("done_k10", {7'b0, done}, {7'b0, key0 && key1});
        chk("out_k10", out, key0 ? res : 8'h00);
        if (key0 && key1) begin
            repeat (2) @(negedge clk);
            chk("done_hold", {7'b0, done}, 8'h01);
            chk("out_hold", out, res);
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            chk("done_exit", {7'b0, done}, 8'h00);
            chk("out_exit", out, res);
            @(negedge clk);
            chk("idle_stay", {7'b0, done}, 8'h00);
        end else begin
            repeat (3) @(negedge clk);
            chk("fail_done", {7'b0, done}, 8'h00);
            chk("fail_out", out, key0 ? res : 8'h00);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        en  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        #1;
        chk("reset_out", out, 8'h00);
        chk("reset_done", {7'b0, done}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_out", out, 8'h00);

        run_op(8'h48, 8'hD5, 0);
        run_op(8'h00, 8'hD4, 0);
        run_op(8'h30, 8'hD6, 0);
        run_op(8'h04, 8'h5A, 0);
        run_op(8'h4A, 8'hD5, 0);

        // Reset during the fourth SUB cycle.
        @(negedge clk);
        a  = 8'h48;
        b  = 8'hD5;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", out, 8'h00);
        chk("midrst_done", {7'b0, done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_idle_done", {7'b0, done}, 8'h00);
        chk("midrst_idle_out", out, 8'h00);
        run_op(8'h48, 8'hD5, 0);

        // en held high throughout: exit DONE then reload next edge.
        @(negedge clk);
        a  = 8'h48;
        b  = 8'hD5;
        en = 1'b1;
        repeat (11) @(negedge clk);
        chk("cont_done", {7'b0, done}, 8'h01);
        chk("cont_out", out, 8'h7A);
        @(negedge clk);
        chk("cont_exit_done", {7'b0, done}, 8'h00);
        chk("cont_exit_out", out, 8'h7A);
        @(negedge clk);
        chk("cont_reload_out", out, 8'h00);
        en = 1'b0;
        repeat (14) @(negedge clk);
        chk("cont_second_done", {7'b0, done}, 8'h01);
        chk("cont_second_out", out, 8'h7A);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (($urandom % 4) != 0) ra[2:1] = 2'b00;
            run_op(ra, rb, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
